// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexing scan controller for a common-anode 7-segment display bank.
// Holds a multi-digit hex value, steps through the digits at a programmable
// refresh rate and presents one nibble at a time to the hex-to-7-segment
// decoder while enabling the matching (active-low) digit anode.
// New values are double-buffered: a load lands in a shadow register and is
// copied to the displayed register only at a frame boundary, so no digit ever
// shows a half-updated value.
//
// Parameters:
//   NUM_DIGITS  - number of digits scanned (2..8)
//   REFRESH_DIV - clock cycles per digit slot (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   scan enable; low holds the counters and blanks all anodes
//   load       in   single-cycle strobe capturing value into the shadow reg
//   value      in   4*NUM_DIGITS bits, digit 0 = bits [3:0] (rightmost)
//   hex_out    out  nibble of the slot being shown (decoder dataIn)
//   anode      out  active-low one-hot digit enable (1 = digit off)
//   frame_done out  one-cycle pulse in the cycle after the last slot ends
//   pending    out  high while a loaded value waits for the frame boundary
//
// Optional feature (compile-time macro SEG7_LEADING_ZERO_BLANK_EN):
//   When defined, a digit keeps its anode off during its slot if its nibble
//   and every higher-index nibble are zero. Digit 0 is never blanked and
//   hex_out is still driven for blanked slots.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  output logic [3:0]                hex_out,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic                      frame_done,
  output logic                      pending
);

  localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t                    r_state;
  logic [PS_W-1:0]           r_prescale;
  logic [IDX_W-1:0]          r_digit_idx;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [4*NUM_DIGITS-1:0]   r_disp;
  logic                      r_pend_flag;

  logic                      w_tick;
  logic                      w_boundary;
  logic [3:0]                w_nibble;
  logic                      w_dark;
  logic [NUM_DIGITS-1:0]     w_anode;

  // Slot and frame events only exist while scanning.
  assign w_tick     = (r_state == S_SCAN) && (r_prescale == PS_LAST);
  assign w_boundary = w_tick && (r_digit_idx == IDX_LAST);

  // Nibble of the currently selected digit.
  always_comb begin
    w_nibble = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) w_nibble = r_disp[4*i +: 4];
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // w_zero_up[i]: nibble i and every nibble above it are zero.
  logic [NUM_DIGITS-1:0] w_zero_up;

  always_comb begin
    w_zero_up = '0;
    w_zero_up[NUM_DIGITS-1] = (r_disp[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS-2; i >= 0; i--) begin
      w_zero_up[i] = w_zero_up[i+1] && (r_disp[4*i +: 4] == 4'h0);
    end
  end

  // Digit 0 is excluded so an all-zero value still shows a single "0".
  always_comb begin
    w_dark = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) w_dark = w_zero_up[i];
    end
  end
`else
  assign w_dark = 1'b0;
`endif

  // Active-low one-hot enable for the current slot; a dark slot stays off.
  always_comb begin
    w_anode = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) w_anode[i] = w_dark;
    end
  end

  // Control FSM, counters, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prescale  <= '0;
      r_digit_idx <= '0;
      r_shadow    <= '0;
      r_disp      <= '0;
      r_pend_flag <= 1'b0;
      hex_out     <= 4'h0;
      anode       <= '1;
      frame_done  <= 1'b0;
    end else begin
      r_state <= enable ? S_SCAN : S_IDLE;

      case (r_state)
        S_IDLE: begin
          // Counters hold so scanning resumes in the same slot.
          anode <= '1;
        end
        S_SCAN: begin
          anode <= w_anode;
          if (w_tick) begin
            r_prescale  <= '0;
            r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
          end else begin
            r_prescale  <= r_prescale + 1'b1;
          end
        end
        default: anode <= '1;
      endcase

      hex_out    <= w_nibble;
      frame_done <= w_boundary;

      // A load coinciding with the boundary bypasses the shadow register.
      if (w_boundary) begin
        if (load)             r_disp <= value;
        else if (r_pend_flag) r_disp <= r_shadow;
      end

      if (load) r_shadow <= value;

      if (load)            r_pend_flag <= !w_boundary;
      else if (w_boundary) r_pend_flag <= 1'b0;
    end
  end

  assign pending = r_pend_flag;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller for the board's common-anode 7-segment display bank. It holds a multi-digit hex value, steps through the digits at a programmable refresh rate, and drives one nibble at a time into the hex-to-7-segment decoder while enabling the matching digit anode. New values are double-buffered and applied only at frame boundaries, so a digit never shows a half-updated value.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned (2..8).
- `REFRESH_DIV`, default 50000: clock cycles per digit slot (≥1).

Ports:
- `clk` input, 1 bit: single system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: scan enable. When low, the counters hold and all anodes are off.
- `load` input, 1 bit: single-cycle strobe that captures `value`.
- `value` input, 4*NUM_DIGITS bits: hex value to display. Digit 0 is bits [3:0] and is the rightmost digit.
- `hex_out` output, 4 bits: nibble for the digit currently selected. Feeds the decoder's `dataIn`.
- `anode` output, NUM_DIGITS bits: active-low one-hot digit enable. A bit value of 1 means the digit is off.
- `frame_done` output, 1 bit: one-cycle pulse when the last digit slot ends.
- `pending` output, 1 bit: high while a loaded value waits for the frame boundary.

## Operation
- Registers:
  - `prescale`: 0..REFRESH_DIV-1.
  - `digit_idx`: 0..NUM_DIGITS-1.
  - `shadow_reg`: holds the last `value` captured by `load`.
  - `disp_reg`: the value actually being displayed.
  - `pend_flag`: set when a loaded value has not yet been applied.
- Reset values: `prescale`=0, `digit_idx`=0, `shadow_reg`=0, `disp_reg`=0, `pend_flag`=0. Outputs after reset: `anode` all ones, `hex_out`=0, `frame_done`=0, `pending`=0.
- State machine, two states:
  - IDLE: entered at reset and whenever `enable` is low. `anode` is all ones; `prescale` and `digit_idx` hold.
  - SCAN: entered when `enable` is high.
- SCAN behaviour:
  - `prescale` increments each cycle.
  - A `tick` occurs when `prescale`==REFRESH_DIV-1; `prescale` then wraps to 0.
  - On `tick`, `digit_idx` increments, wrapping from NUM_DIGITS-1 to 0.
  - Dropping `enable` returns to IDLE without resetting `prescale` or `digit_idx`. Scanning resumes from the same slot.
- Outputs in SCAN:
  - `hex_out` = `disp_reg[4*digit_idx +: 4]`.
  - `anode` = ~(1 << `digit_idx`).
  - `hex_out` is still driven in IDLE.
- Frame boundary: a `tick` while `digit_idx`==NUM_DIGITS-1. In that cycle, `disp_reg` ← `shadow_reg` if `pend_flag` is set, and `pend_flag` clears.
- Load rules:
  - `load` sets `shadow_reg` ← `value` and `pend_flag` ← 1.
  - If several loads occur before a boundary, the last one wins.
  - If `load` and a frame boundary occur in the same cycle, `disp_reg` takes the incoming `value` directly and `pend_flag` ends at 0.
- `load` is accepted in both states.

## Timing
- `anode`, `hex_out`, `frame_done` and `pending` are all registered. They change one cycle after the internal event that causes them.
- Digit slot length: exactly REFRESH_DIV cycles.
- Frame length: NUM_DIGITS × REFRESH_DIV cycles.
- `frame_done`: high for exactly one cycle, in the cycle after a boundary tick.
- `pending`: rises in the cycle after `load`. It falls in the same cycle that `frame_done` rises.
- Load-to-display latency:
  - Worst case: one frame plus 1 cycle.
  - Best case: 1 cycle, when `load` coincides with the boundary.
- REFRESH_DIV=1: a tick every cycle, so the digit advances every clock.
- `rst_n` asserted mid-frame: all registers clear immediately, asynchronously. Any pending value is lost and the display blanks.

## Configuration
- Macro `SEG7_LEADING_ZERO_BLANK_EN`.
- Defined:
  - A digit slot keeps its anode off when its `disp_reg` nibble is 0 and every higher-index nibble is also 0.
  - Digit 0 is never blanked, so a displayed value of 0 shows a single "0".
  - `hex_out` is still driven for blanked slots.
- Undefined: every digit is always lit during its slot.

## Test plan
- Reset, then `enable`=1 with NUM_DIGITS=4 and REFRESH_DIV=4 -> `anode` cycles 1110, 1101, 1011, 0111 with 4 cycles each; `frame_done` pulses every 16 cycles; `hex_out`=0.
- `load` of `value`=16'hA3F1 mid-frame -> `pending`=1 until the boundary; at the next frame `hex_out` is 1, F, 3, A on digits 0..3 and `pending`=0.
- Two loads, 16'h1111 then 16'h2222, in one frame -> the next frame shows only 2222.
- `load` of 16'h5A5A in the exact cycle of a boundary tick -> `pending` never rises; the next frame shows 5A5A.
- `enable` dropped during digit 2 for 10 cycles -> `anode`=1111 while low; on re-enable, digit 2 resumes with its remaining prescale count.
- With `SEG7_LEADING_ZERO_BLANK_EN`, `value`=16'h0030 -> digits 3 and 2 stay dark in their slots while digits 1 and 0 light, showing "30". Then `value`=0 -> only digit 0 lights, showing "0".
